skeleton_frame_feeder: RTL and testbench
========================================

Name: skeleton_frame_feeder

Overview:
- Transmit side of the skeletonizer's pixel input interface: pixel_in, hcount_in, vcount_in, pixel_valid_in, with busy as back-pressure.
- Captures one complete binary mask frame from the downscaled mask stream into a 1-bit frame BRAM.
- Once the skeletonizer is idle, replays the frame as a gap-free raster burst, then waits for that frame's skeletonization to finish before arming again.
- Guarantees the skeletonizer never sees a partial frame or pixels while busy; frames arriving during that window are dropped and counted.

Parameters:
- HORIZONTAL_COUNT, 320, frame width in pixels.
- VERTICAL_COUNT, 180, frame height in pixels.
- ACK_TIMEOUT, 8, cycles to wait for skel_busy_in to rise after the last pixel is sent.

Ports:
- clk_in  input  1  system clock; the only clock.
- rst_n_in  input  1  asynchronous active-low reset.
- mask_in  input  1  binary mask pixel.
- mask_hcount_in  input  HWIDTH  column of mask_in; HWIDTH=$clog2(HORIZONTAL_COUNT).
- mask_vcount_in  input  VWIDTH  row of mask_in; VWIDTH=$clog2(VERTICAL_COUNT).
- mask_valid_in  input  1  mask_in qualifier.
- skel_busy_in  input  1  skeletonizer busy.
- pixel_out  output  1  pixel to skeletonizer.
- hcount_out  output  HWIDTH  column of pixel_out.
- vcount_out  output  VWIDTH  row of pixel_out.
- pixel_valid_out  output  1  pixel_out qualifier.
- feeder_idle_out  output  1  high in ARM state only.
- ack_timeout_out  output  1  one-cycle pulse when ACK_TIMEOUT expires.
- frames_sent_out  output  16  frames fully streamed; wraps at 16 bits.
- frames_dropped_out  output  16  frames ignored; saturates at 16'hFFFF.

Behaviour:
- Reset: asynchronous and active-low. Every output is 0 and the state is ARM while rst_n_in=0. BRAM contents are not cleared.
- States:
  - ARM: on mask_valid_in with (h,v)=(0,0), write the pixel and go to CAPTURE.
  - CAPTURE:
    - Write each valid pixel at address v*HORIZONTAL_COUNT+h.
    - A valid (0,0) restarts the capture and writes pixel (0,0) again; no drop is counted.
    - A valid last pixel (HORIZONTAL_COUNT-1, VERTICAL_COUNT-1) is written, then go to WAIT_IDLE.
  - WAIT_IDLE: when skel_busy_in=0, go to STREAM.
  - STREAM:
    - Issue one read address per cycle in raster order, no gaps.
    - After issuing the last address, go to WAIT_ACK with the timeout counter cleared.
  - WAIT_ACK:
    - If skel_busy_in=1, go to WAIT_DONE.
    - If the counter reaches ACK_TIMEOUT, pulse ack_timeout_out and go to ARM.
  - WAIT_DONE: when skel_busy_in=0, go to ARM.
- Counters:
  - frames_sent_out increments in the cycle the last pixel has pixel_valid_out=1.
  - frames_dropped_out increments on each valid (0,0) in WAIT_IDLE, STREAM, WAIT_ACK or WAIT_DONE.
- Mask pixels arriving outside ARM and CAPTURE are never written.
- Read latency: the BRAM runs in high-performance mode (2-cycle read).
  - Address issued in cycle t gives pixel_out in cycle t+2.
  - hcount/vcount and valid travel through a matched 2-stage pipeline.
  - First pixel_valid_out is 3 cycles after the FSM enters STREAM (enter, issue, +2).
  - pixel_valid_out stays high for exactly HORIZONTAL_COUNT*VERTICAL_COUNT consecutive cycles.
  - Those cycles include the 2 drain cycles after the state has left STREAM.
- skel_busy_in rising during STREAM (a protocol violation): the stream still completes; no abort.
- Read and write never overlap, because capture only happens in ARM and CAPTURE.
- Address width is $clog2(HORIZONTAL_COUNT*VERTICAL_COUNT). The multiply uses the registered (h,v) and the write is registered one cycle.

Decomposition:
- Package skeleton_pkg:
  - feeder_state_t enum: ARM, CAPTURE, WAIT_IDLE, STREAM, WAIT_ACK, WAIT_DONE.
  - HWIDTH/VWIDTH helpers.
- Sub-module: the existing xilinx_true_dual_port_read_first_1_clock_ram.
  - Port A for writes, port B for reads, RAM_WIDTH=1.
- One natural sub-module: raster_counter (h/v counters with wrap, last-pixel flag).
  - Also reused for capture position checking.

Test Plan (bench uses 8x4 frame, ACK_TIMEOUT=8):
- Checkerboard frame captured with skel_busy_in=0 -> 32 consecutive pixel_valid_out cycles; first valid 3 cycles after entering STREAM; data matches the checkerboard; (h,v) goes (0,0)..(7,3); frames_sent_out=1.
- skel_busy_in held 1 through capture, released 50 cycles later -> no valid output before release; first valid 3 cycles after the release edge.
- Second frame sent while in WAIT_DONE -> frames_dropped_out=1; stored data unchanged; replaying after WAIT_DONE is not automatic (next frame only).
- Capture restarts at (0,0) after 10 pixels -> no drop counted; only the second frame is streamed.
- skel_busy_in never rises after streaming -> ack_timeout_out pulses 8 cycles after the last issued address; feeder_idle_out=1 next cycle.
- rst_n_in low mid-STREAM (pixel 12) -> pixel_valid_out=0 asynchronously; counters 0; after release a fresh frame streams correctly.

Source files
------------

// File: rtl/skeleton_pkg.sv
// Shared types and width helpers for the skeletonizer frame feeder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package skeleton_pkg;

    // Feeder sequence: capture a frame, replay it once, then wait for the
    // skeletonizer to finish with it.
    typedef enum logic [2:0] {
        ARM       = 3'd0,
        CAPTURE   = 3'd1,
        WAIT_IDLE = 3'd2,
        STREAM    = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_DONE = 3'd5
    } feeder_state_t;

    // Column index width; never narrower than one bit.
    function automatic int calc_hwidth(input int horizontal_count);
        return (horizontal_count > 1) ? $clog2(horizontal_count) : 1;
    endfunction

    // Row index width; never narrower than one bit.
    function automatic int calc_vwidth(input int vertical_count);
        return (vertical_count > 1) ? $clog2(vertical_count) : 1;
    endfunction

    // Linear frame-buffer address width.
    function automatic int calc_awidth(input int horizontal_count, input int vertical_count);
        return (horizontal_count * vertical_count > 1) ? $clog2(horizontal_count * vertical_count) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position generator (h/v/linear address, wrap, last flag) plus a position probe.
// Latency: position updates one cycle after step_i; probe flags are combinational.
// Backpressure: holds position while step_i is low; clear_i has priority.
module raster_counter
    import skeleton_pkg::*;
#(
    parameter int HORIZONTAL_COUNT = 320,
    parameter int VERTICAL_COUNT   = 180,
    parameter int HWIDTH           = calc_hwidth(HORIZONTAL_COUNT),
    parameter int VWIDTH           = calc_vwidth(VERTICAL_COUNT),
    parameter int AWIDTH           = calc_awidth(HORIZONTAL_COUNT, VERTICAL_COUNT)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic              step_i,
    output logic [HWIDTH-1:0] h_o,
    output logic [VWIDTH-1:0] v_o,
    output logic [AWIDTH-1:0] addr_o,
    output logic              last_o,
    input  logic [HWIDTH-1:0] probe_h_i,
    input  logic [VWIDTH-1:0] probe_v_i,
    output logic              probe_first_o,
    output logic              probe_last_o
);

    localparam logic [HWIDTH-1:0] H_LAST = HWIDTH'(HORIZONTAL_COUNT - 1);
    localparam logic [VWIDTH-1:0] V_LAST = VWIDTH'(VERTICAL_COUNT - 1);

    logic [HWIDTH-1:0] h_q, h_d;
    logic [VWIDTH-1:0] v_q, v_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              h_wrap;
    logic              v_wrap;

    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);

    // Next position: advance along the row, wrap to the next row, wrap the frame after the last pixel.
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        addr_d = addr_q;
        if (clear_i) begin
            h_d    = '0;
            v_d    = '0;
            addr_d = '0;
        end else if (step_i) begin
            if (h_wrap) begin
                h_d = '0;
                v_d = v_wrap ? '0 : v_q + VWIDTH'(1);
            end else begin
                h_d = h_q + HWIDTH'(1);
            end
            addr_d = (h_wrap && v_wrap) ? '0 : addr_q + AWIDTH'(1);
        end
    end

    // Position registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_q    <= '0;
            v_q    <= '0;
            addr_q <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            addr_q <= addr_d;
        end
    end

    assign h_o    = h_q;
    assign v_o    = v_q;
    assign addr_o = addr_q;
    assign last_o = h_wrap && v_wrap;

    // The same frame geometry classifies an arbitrary incoming position.
    assign probe_first_o = (probe_h_i == '0) && (probe_v_i == '0);
    assign probe_last_o  = (probe_h_i == H_LAST) && (probe_v_i == V_LAST);

endmodule

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// True dual-port, read-first, single-clock block RAM.
// Latency: 1 cycle (LOW_LATENCY) or 2 cycles with output register (HIGH_PERFORMANCE).
// Backpressure: none; each port accepts one access per enabled cycle.
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int    RAM_WIDTH       = 18,
    parameter int    RAM_DEPTH       = 1024,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic [RAM_WIDTH-1:0]         dinb,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         web,
    input  logic                         ena,
    input  logic                         enb,
    input  logic                         rsta,
    input  logic                         rstb,
    input  logic                         regcea,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         douta,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] ram_q [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_a;
    logic [RAM_WIDTH-1:0] ram_data_b;

    // Both ports share one process so the array has a single driver; read-first ordering.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                ram_q[addra] <= dina;
            end
            ram_data_a <= ram_q[addra];
        end
        if (enb) begin
            if (web) begin
                ram_q[addrb] <= dinb;
            end
            ram_data_b <= ram_q[addrb];
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
            assign douta = ram_data_a;
            assign doutb = ram_data_b;
        end else begin : g_out_reg
            logic [RAM_WIDTH-1:0] douta_reg;
            logic [RAM_WIDTH-1:0] doutb_reg;

            // Output register stage with synchronous reset and clock enable.
            always_ff @(posedge clka) begin
                if (rsta) begin
                    douta_reg <= '0;
                end else if (regcea) begin
                    douta_reg <= ram_data_a;
                end
                if (rstb) begin
                    doutb_reg <= '0;
                end else if (regceb) begin
                    doutb_reg <= ram_data_b;
                end
            end

            assign douta = douta_reg;
            assign doutb = doutb_reg;
        end
    endgenerate

endmodule

// File: rtl/skeleton_frame_feeder.sv
// Captures one binary mask frame into a 1-bit BRAM and replays it to the skeletonizer as a gap-free raster burst.
// Latency: write lands 1 cycle after mask_valid_in; first pixel_valid_out 3 cycles after entering STREAM.
// Backpressure: skel_busy_in holds replay in WAIT_IDLE; frames starting outside ARM/CAPTURE are dropped and counted.
module skeleton_frame_feeder
    import skeleton_pkg::*;
#(
    parameter int  HORIZONTAL_COUNT = 320,
    parameter int  VERTICAL_COUNT   = 180,
    parameter int  ACK_TIMEOUT      = 8,
    localparam int HWIDTH           = calc_hwidth(HORIZONTAL_COUNT),
    localparam int VWIDTH           = calc_vwidth(VERTICAL_COUNT)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              mask_in,
    input  logic [HWIDTH-1:0] mask_hcount_in,
    input  logic [VWIDTH-1:0] mask_vcount_in,
    input  logic              mask_valid_in,
    input  logic              skel_busy_in,
    output logic              pixel_out,
    output logic [HWIDTH-1:0] hcount_out,
    output logic [VWIDTH-1:0] vcount_out,
    output logic              pixel_valid_out,
    output logic              feeder_idle_out,
    output logic              ack_timeout_out,
    output logic [15:0]       frames_sent_out,
    output logic [15:0]       frames_dropped_out
);

    localparam int AWIDTH = calc_awidth(HORIZONTAL_COUNT, VERTICAL_COUNT);
    localparam int ACKW   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ACKW-1:0] ACK_LAST = ACKW'(ACK_TIMEOUT - 1);

    feeder_state_t state_q, state_d;
    logic [ACKW-1:0] ack_cnt_q, ack_cnt_d;
    logic            wr_en_d;
    logic            drop_evt;
    logic            gen_en;
    logic            gen_done_q;

    // Capture side: inputs registered, address formed from the registered position.
    logic              wr_en_q;
    logic              wr_dat_q;
    logic [HWIDTH-1:0] wr_h_q;
    logic [VWIDTH-1:0] wr_v_q;
    logic [AWIDTH-1:0] wr_addr;

    // Replay side: issue register followed by the 2-stage BRAM-matched pipeline.
    logic              cnt_clear;
    logic [HWIDTH-1:0] cnt_h;
    logic [VWIDTH-1:0] cnt_v;
    logic [AWIDTH-1:0] cnt_addr;
    logic              cnt_last;
    logic              in_first;
    logic              in_last;
    logic              rd_vld_q, p1_vld_q, p2_vld_q;
    logic              rd_last_q, p1_last_q, p2_last_q;
    logic [AWIDTH-1:0] rd_addr_q;
    logic [HWIDTH-1:0] rd_h_q, p1_h_q, p2_h_q;
    logic [VWIDTH-1:0] rd_v_q, p1_v_q, p2_v_q;
    logic              ram_dout;
    logic              ram_douta_unused;

    logic [15:0] frames_sent_q;
    logic [15:0] frames_dropped_q;
    logic        idle_q;

    assign cnt_clear = (state_q != STREAM);

    raster_counter #(
        .HORIZONTAL_COUNT (HORIZONTAL_COUNT),
        .VERTICAL_COUNT   (VERTICAL_COUNT),
        .HWIDTH           (HWIDTH),
        .VWIDTH           (VWIDTH),
        .AWIDTH           (AWIDTH)
    ) u_raster (
        .clk_i         (clk_in),
        .rst_n_i       (rst_n_in),
        .clear_i       (cnt_clear),
        .step_i        (gen_en),
        .h_o           (cnt_h),
        .v_o           (cnt_v),
        .addr_o        (cnt_addr),
        .last_o        (cnt_last),
        .probe_h_i     (mask_hcount_in),
        .probe_v_i     (mask_vcount_in),
        .probe_first_o (in_first),
        .probe_last_o  (in_last)
    );

    // Sequencer: capture, wait for idle, replay, then wait for the skeletonizer to take and finish the frame.
    always_comb begin
        state_d         = state_q;
        ack_cnt_d       = ack_cnt_q;
        wr_en_d         = 1'b0;
        gen_en          = 1'b0;
        ack_timeout_out = 1'b0;
        unique case (state_q)
            ARM: begin
                if (mask_valid_in && in_first) begin
                    wr_en_d = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (mask_valid_in) begin
                    wr_en_d = 1'b1;
                    if (in_last) begin
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (!skel_busy_in) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                gen_en    = !gen_done_q;
                ack_cnt_d = '0;
                // Leave only once the last address has actually reached the BRAM.
                if (rd_vld_q && rd_last_q) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (skel_busy_in) begin
                    state_d = WAIT_DONE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    ack_timeout_out = 1'b1;
                    state_d         = ARM;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACKW'(1);
                end
            end
            WAIT_DONE: begin
                if (!skel_busy_in) begin
                    state_d = ARM;
                end
            end
            default: state_d = ARM;
        endcase
    end

    // A frame start seen while the buffer is committed to a pending or running replay is lost.
    assign drop_evt = mask_valid_in && in_first &&
                      (state_q inside {WAIT_IDLE, STREAM, WAIT_ACK, WAIT_DONE});

    // Control state, counters and status outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q          <= ARM;
            ack_cnt_q        <= '0;
            gen_done_q       <= 1'b0;
            frames_sent_q    <= '0;
            frames_dropped_q <= '0;
            idle_q           <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_cnt_q  <= ack_cnt_d;
            gen_done_q <= (state_q == STREAM) && (gen_done_q || (gen_en && cnt_last));
            idle_q     <= (state_d == ARM);
            if (p2_vld_q && p2_last_q) begin
                frames_sent_q <= frames_sent_q + 16'd1;
            end
            if (drop_evt && (frames_dropped_q != 16'hFFFF)) begin
                frames_dropped_q <= frames_dropped_q + 16'd1;
            end
        end
    end

    // Capture write stage: one registered cycle between the mask stream and the BRAM.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_en_q  <= 1'b0;
            wr_dat_q <= 1'b0;
            wr_h_q   <= '0;
            wr_v_q   <= '0;
        end else begin
            wr_en_q  <= wr_en_d;
            wr_dat_q <= mask_in;
            wr_h_q   <= mask_hcount_in;
            wr_v_q   <= mask_vcount_in;
        end
    end

    assign wr_addr = AWIDTH'(wr_v_q) * AWIDTH'(HORIZONTAL_COUNT) + AWIDTH'(wr_h_q);

    // Replay issue register and the position/valid pipeline matched to the 2-cycle BRAM read.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            rd_addr_q <= '0;
            rd_h_q    <= '0;
            rd_v_q    <= '0;
            p1_vld_q  <= 1'b0;
            p1_last_q <= 1'b0;
            p1_h_q    <= '0;
            p1_v_q    <= '0;
            p2_vld_q  <= 1'b0;
            p2_last_q <= 1'b0;
            p2_h_q    <= '0;
            p2_v_q    <= '0;
        end else begin
            rd_vld_q  <= gen_en;
            rd_last_q <= cnt_last;
            rd_addr_q <= cnt_addr;
            rd_h_q    <= cnt_h;
            rd_v_q    <= cnt_v;
            p1_vld_q  <= rd_vld_q;
            p1_last_q <= rd_last_q;
            p1_h_q    <= rd_h_q;
            p1_v_q    <= rd_v_q;
            p2_vld_q  <= p1_vld_q;
            p2_last_q <= p1_last_q;
            p2_h_q    <= p1_h_q;
            p2_v_q    <= p1_v_q;
        end
    end

    xilinx_true_dual_port_read_first_1_clock_ram #(
        .RAM_WIDTH       (1),
        .RAM_DEPTH       (HORIZONTAL_COUNT * VERTICAL_COUNT),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
    ) u_frame_ram (
        .addra  (wr_addr),
        .addrb  (rd_addr_q),
        .dina   (wr_dat_q),
        .dinb   (1'b0),
        .clka   (clk_in),
        .wea    (wr_en_q),
        .web    (1'b0),
        .ena    (wr_en_q),
        .enb    (rd_vld_q),
        .rsta   (1'b0),
        .rstb   (1'b0),
        .regcea (1'b0),
        .regceb (1'b1),
        .douta  (ram_douta_unused),
        .doutb  (ram_dout)
    );

    // The BRAM output register is not reset, so the pixel is qualified by the reset pipeline valid.
    assign pixel_out          = ram_dout & p2_vld_q;
    assign pixel_valid_out    = p2_vld_q;
    assign hcount_out         = p2_h_q;
    assign vcount_out         = p2_v_q;
    assign feeder_idle_out    = idle_q;
    assign frames_sent_out    = frames_sent_q;
    assign frames_dropped_out = frames_dropped_q;

endmodule

// File: tb/tb_skeleton_frame_feeder.sv
// Directed bench for the frame feeder on an 8x4 frame with ACK_TIMEOUT=8.
// Latency: expectations are cycle-exact against the sequencer timing.
// Backpressure: drives skel_busy_in directly to exercise idle gating and drops.
module tb_skeleton_frame_feeder;

    localparam int HC = 8;
    localparam int VC = 4;

    logic        clk;
    logic        rst_n;
    logic        mask;
    logic [2:0]  mask_h;
    logic [1:0]  mask_v;
    logic        mask_vld;
    logic        skel_busy;
    logic        pixel_out;
    logic [2:0]  hcount_out;
    logic [1:0]  vcount_out;
    logic        pixel_valid_out;
    logic        feeder_idle_out;
    logic        ack_timeout_out;
    logic [15:0] frames_sent_out;
    logic [15:0] frames_dropped_out;

    int n_chk  = 0;
    int n_fail = 0;

    skeleton_frame_feeder #(
        .HORIZONTAL_COUNT (HC),
        .VERTICAL_COUNT   (VC),
        .ACK_TIMEOUT      (8)
    ) dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .mask_in            (mask),
        .mask_hcount_in     (mask_h),
        .mask_vcount_in     (mask_v),
        .mask_valid_in      (mask_vld),
        .skel_busy_in       (skel_busy),
        .pixel_out          (pixel_out),
        .hcount_out         (hcount_out),
        .vcount_out         (vcount_out),
        .pixel_valid_out    (pixel_valid_out),
        .feeder_idle_out    (feeder_idle_out),
        .ack_timeout_out    (ack_timeout_out),
        .frames_sent_out    (frames_sent_out),
        .frames_dropped_out (frames_dropped_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_pixel(input int h, input int v, input logic bit_val);
        mask     = bit_val;
        mask_h   = 3'(h);
        mask_v   = 2'(v);
        mask_vld = 1'b1;
        tick();
        mask_vld = 1'b0;
    endtask

    // Sends the first npix pixels of a frame; bit i of f is the pixel at v*8+h.
    task automatic send_frame(input logic [31:0] f, input int npix);
        for (int i = 0; i < npix; i++) begin
            send_pixel(i % HC, i / HC, f[i]);
        end
    endtask

    task automatic check_stream(input string tag, input logic [31:0] exp, input bit raise_busy);
        int         k;
        logic [6:0] got;
        logic [6:0] want;
        k = 0;
        while (!pixel_valid_out && k < 100) begin
            tick();
            k++;
        end
        chk({tag, " first_valid_delay"}, k, 4);
        if (!pixel_valid_out) return;
        for (int i = 0; i < HC * VC; i++) begin
            got  = {pixel_valid_out, pixel_out, vcount_out, hcount_out};
            want = {1'b1, exp[i], 2'(i / HC), 3'(i % HC)};
            chk($sformatf("%s px%0d {vld,pix,v,h}", tag, i), 32'(got), 32'(want));
            tick();
        end
        chk({tag, " valid_after_burst"}, 32'(pixel_valid_out), 0);
        if (raise_busy) begin
            skel_busy = 1'b1;
        end else begin
            k = 0;
            while (!ack_timeout_out && k < 20) begin
                tick();
                k++;
            end
            chk({tag, " ack_timeout_delay"}, k, 5);
            tick();
            chk({tag, " ack_timeout_single"}, 32'(ack_timeout_out), 0);
            chk({tag, " idle_after_timeout"}, 32'(feeder_idle_out), 1);
        end
    endtask

    initial begin
        int k;
        int vcnt;
        rst_n     = 1'b0;
        mask      = 1'b0;
        mask_h    = '0;
        mask_v    = '0;
        mask_vld  = 1'b0;
        skel_busy = 1'b0;
        tick();
        tick();

        // Reset state.
        chk("rst pixel_valid", 32'(pixel_valid_out), 0);
        chk("rst pixel", 32'(pixel_out), 0);
        chk("rst idle", 32'(feeder_idle_out), 0);
        chk("rst ack", 32'(ack_timeout_out), 0);
        chk("rst sent", 32'(frames_sent_out), 0);
        chk("rst dropped", 32'(frames_dropped_out), 0);
        rst_n = 1'b1;
        tick();
        chk("armed idle", 32'(feeder_idle_out), 1);

        // Checkerboard, skeletonizer idle throughout; times out waiting for busy.
        send_frame(32'h55AA55AA, 32);
        check_stream("checker", 32'h55AA55AA, 1'b0);
        chk("checker sent", 32'(frames_sent_out), 1);
        chk("checker dropped", 32'(frames_dropped_out), 0);

        // Busy held through capture, released 50 cycles later.
        skel_busy = 1'b1;
        send_frame(32'hAA55AA55, 32);
        vcnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (pixel_valid_out) vcnt++;
            tick();
        end
        chk("busy hold no_valid", vcnt, 0);
        chk("busy hold not_idle", 32'(feeder_idle_out), 0);
        skel_busy = 1'b0;
        check_stream("released", 32'hAA55AA55, 1'b1);
        chk("released sent", 32'(frames_sent_out), 2);

        // Frame arriving in WAIT_DONE is dropped and not written.
        tick();
        tick();
        tick();
        send_frame(32'hFFFFFFFF, 32);
        chk("wait_done dropped", 32'(frames_dropped_out), 1);
        skel_busy = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (pixel_valid_out) vcnt++;
            tick();
        end
        chk("no auto replay", vcnt, 0);
        chk("idle after done", 32'(feeder_idle_out), 1);
        // Only the first and last pixels are rewritten; the rest must still be the previous frame.
        send_pixel(0, 0, 1'b0);
        send_pixel(7, 3, 1'b0);
        check_stream("sparse", 32'h2A55AA54, 1'b0);
        chk("sparse sent", 32'(frames_sent_out), 3);

        // Capture restarted at (0,0) after 10 pixels.
        send_frame(32'h0F0F0F0F, 10);
        send_frame(32'h12345678, 32);
        check_stream("restart", 32'h12345678, 1'b0);
        chk("restart dropped", 32'(frames_dropped_out), 1);
        chk("restart sent", 32'(frames_sent_out), 4);

        // Asynchronous reset in the middle of a replay.
        send_frame(32'hDEADBEEF, 32);
        k = 0;
        while (!pixel_valid_out && k < 100) begin
            tick();
            k++;
        end
        for (int i = 0; i < 12; i++) tick();
        chk("midstream valid", 32'(pixel_valid_out), 1);
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 32'(pixel_valid_out), 0);
        chk("async rst pixel", 32'(pixel_out), 0);
        chk("async rst hcount", 32'(hcount_out), 0);
        chk("async rst sent", 32'(frames_sent_out), 0);
        chk("async rst dropped", 32'(frames_dropped_out), 0);
        chk("async rst idle", 32'(feeder_idle_out), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post rst idle", 32'(feeder_idle_out), 1);
        send_frame(32'hC3C33C3C, 32);
        check_stream("post_rst", 32'hC3C33C3C, 1'b0);
        chk("post rst sent", 32'(frames_sent_out), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
